hex_seg7_scan: RTL and testbench

//  Multiplexed 7-segment scanner. Consumes the 32-bit word driven on ext_hex_led
//  and shows it as DIGITS hex digits on a common-anode display.

---
 rtl/hex_seg7_scan.sv | 140 ++++++++++++++
 tb/tb_hex_seg7_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hex_seg7_scan.sv
// hex_seg7_scan: multiplexed common-anode 7-segment scanner for a 32-bit hex word.
// A new word is captured into a pending buffer on load and only swapped into the
// display word at a frame boundary, so a frame never mixes two values.
// Optional feature: define HEX_SEG7_LZB_EN to blank leading-zero digits.
// Outputs are registered from the current scan state, so they trail it by one cycle.
// Handshake: load is a plain 1-cycle strobe with no back-pressure; data/dp are
// sampled on the rising edge where load=1, and the last strobe before a frame
// boundary wins.
module hex_seg7_scan #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        load,
    input  logic [7:0]  dp,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [7:0]  dig,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] CNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    logic [PW-1:0] cnt;
    logic [2:0]    idx;
    logic          wrap;
    logic          boundary;

    logic [31:0]   disp_data;
    logic [7:0]    disp_dp;
    logic [31:0]   pend_data;
    logic [7:0]    pend_dp;
    logic          pend_valid;

    logic [3:0]    nibble;
    logic [6:0]    decoded;
    logic          digit_blank;

    assign wrap     = (cnt == CNT_LAST);
    assign boundary = wrap && (idx == IDX_LAST);

    // Prescaler and digit index: one slot of SCAN_DIV cycles per digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // Double buffer: pending word collects loads, display word swaps at frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (load && boundary) begin
            // A load landing on the swap cycle is newer than anything pending.
            disp_data  <= data;
            disp_dp    <= dp;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_valid <= 1'b1;
        end else if (boundary && pend_valid) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            pend_valid <= 1'b0;
        end
    end

    // Select the nibble of the digit currently being scanned and decode it.
    always_comb begin
        nibble = disp_data[{idx, 2'b00} +: 4];
        case (nibble)
            4'h0: decoded = 7'h40;
            4'h1: decoded = 7'h79;
            4'h2: decoded = 7'h24;
            4'h3: decoded = 7'h30;
            4'h4: decoded = 7'h19;
            4'h5: decoded = 7'h12;
            4'h6: decoded = 7'h02;
            4'h7: decoded = 7'h78;
            4'h8: decoded = 7'h00;
            4'h9: decoded = 7'h10;
            4'hA: decoded = 7'h08;
            4'hB: decoded = 7'h03;
            4'hC: decoded = 7'h46;
            4'hD: decoded = 7'h21;
            4'hE: decoded = 7'h06;
            default: decoded = 7'h0E;
        endcase
    end

`ifdef HEX_SEG7_LZB_EN
    logic [7:0] blank_mask;
    logic       zero_run;

    // Leading-zero mask: digit i blanks when it and every digit above it are zero;
    // digit 0 always shows.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (disp_data[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run && (i != 0);
        end
        digit_blank = blank_mask[idx];
    end
`else
    assign digit_blank = 1'b0;
`endif

    // Registered pin drivers; digit enables are off for the first cycle of each slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= 7'h7F;
            seg_dp     <= 1'b1;
            dig        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= digit_blank ? 7'h7F : decoded;
            seg_dp     <= ~disp_dp[idx];
            dig        <= (cnt == '0) ? 8'hFF : ~(8'b1 << idx);
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_seg7_scan.sv
// tb_hex_seg7_scan: directed bench for hex_seg7_scan with DIGITS=8, SCAN_DIV=4.
// Each frame is 32 cycles; expected segment values come from the hex decode table.
module tb_hex_seg7_scan;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        load;
    logic [7:0]  dp;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [7:0]  dig;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_seg7_scan #(.DIGITS(8), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .load       (load),
        .dp         (dp),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] word, input int i);
        logic [3:0]  nib;
        logic [31:0] upper;
        nib   = word[4*i +: 4];
        upper = word >> (4 * i);
`ifdef HEX_SEG7_LZB_EN
        if (i != 0 && upper == 32'h0) return 7'h7F;
`endif
        return seg_tab[nib];
    endfunction

    // Walk one 32-cycle frame, checking the displayed word and optionally issuing loads.
    // Sample j reflects scan position digit j/4, slot cycle j%4. A load set after
    // sample j is captured on the next edge; j=30 lands on the frame boundary.
    task automatic run_frame(input string name, input logic [31:0] word, input logic [7:0] dpw,
                             input int l1_at, input logic [31:0] l1_d, input logic [7:0] l1_dp,
                             input int l2_at, input logic [31:0] l2_d, input int stop_at);
        int i;
        int pos;
        logic [7:0] exp_dig;
        for (int j = 0; j < 32; j++) begin
            @(posedge clk);
            @(negedge clk);
            i   = j / 4;
            pos = j % 4;
            exp_dig = (pos == 0) ? 8'hFF : ~(8'b1 << i);
            check($sformatf("%s dig j=%0d", name, j), {24'h0, dig}, {24'h0, exp_dig});
            check($sformatf("%s tick j=%0d", name, j), {31'h0, frame_tick}, {31'h0, (j == 31)});
            if (pos == 1) begin
                check($sformatf("%s seg d%0d", name, i), {25'h0, seg}, {25'h0, exp_seg(word, i)});
                check($sformatf("%s dp d%0d", name, i), {31'h0, seg_dp}, {31'h0, ~dpw[i]});
            end
            load = 1'b0;
            if (j == l1_at) begin
                data = l1_d;
                dp   = l1_dp;
                load = 1'b1;
            end
            if (j == l2_at) begin
                data = l2_d;
                dp   = 8'h00;
                load = 1'b1;
            end
            if (j == stop_at) return;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " seg"}, {25'h0, seg}, 32'h7F);
        check({name, " seg_dp"}, {31'h0, seg_dp}, 32'h1);
        check({name, " dig"}, {24'h0, dig}, 32'hFF);
        check({name, " tick"}, {31'h0, frame_tick}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        data  = '0;
        dp    = '0;

        // Reset held for 3 cycles.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs($sformatf("rst%0d", k));
        end
        reset = 1'b0;

        // Frame after reset shows zero; load 89ABCDEF in the following frame.
        run_frame("f0", 32'h0, 8'h00, -1, 32'h0, 8'h00, -1, 32'h0, -1);
        run_frame("f1", 32'h0, 8'h00, 10, 32'h89AB_CDEF, 8'h00, -1, 32'h0, -1);
        // Two loads in one frame: only the second reaches the display.
        run_frame("f2", 32'h89AB_CDEF, 8'h00, 5, 32'h1, 8'h00, 20, 32'h2, -1);
        // Load exactly on the boundary cycle goes straight to the next frame.
        run_frame("f3", 32'h2, 8'h00, 30, 32'h5, 8'h00, -1, 32'h0, -1);
        // Decimal point on digit 2 with an all-zero word.
        run_frame("f4", 32'h5, 8'h00, 3, 32'h0, 8'h04, -1, 32'h0, -1);
        run_frame("f5", 32'h0, 8'h04, -1, 32'h0, 8'h00, -1, 32'h0, -1);
        // Pending load, then reset in the middle of digit 5.
        run_frame("f6", 32'h0, 8'h04, 5, 32'h77, 8'hFF, -1, 32'h0, 22);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        run_frame("f7", 32'h0, 8'h00, -1, 32'h0, 8'h00, -1, 32'h0, -1);
        run_frame("f8", 32'h0, 8'h00, -1, 32'h0, 8'h00, -1, 32'h0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
